// File: rtl/rr_arbiter.sv
// Four-requester round-robin arbiter with a bounded grant quantum.
// Grants are registered and one-hot. Every release or revocation passes
// through one all-zero turnaround cycle. A holder that has used its full
// quantum is revoked when another requester is waiting.
module rr_arbiter #(
   parameter int unsigned QUANTUM = 4
) (
   input  logic       i_clock,
   input  logic       i_rst_n,
   input  logic       i_req0,
   input  logic       i_req1,
   input  logic       i_req2,
   input  logic       i_req3,
   output logic       o_gnt0,
   output logic       o_gnt1,
   output logic       o_gnt2,
   output logic       o_gnt3,
   output logic [1:0] o_gnt_id,
   output logic       o_busy,
   output logic       o_expire
);

   localparam logic [3:0] LP_QUANTUM = 4'(QUANTUM);

   typedef enum logic [0:0] {
      StIdle,
      StGrant
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_gnt;
   logic [3:0] w_gnt_nxt;
   logic [1:0] r_last;
   logic [1:0] w_last_nxt;
   logic [3:0] r_cnt;
   logic [3:0] w_cnt_nxt;
   logic       r_busy;
   logic       w_busy_nxt;
   logic       r_expire;
   logic       w_expire_nxt;

   logic [3:0] w_req;
   logic [3:0] w_hold_mask;
   logic       w_others;
   logic       w_win_vld;
   logic [1:0] w_win_idx;

   assign w_req       = {i_req3, i_req2, i_req1, i_req0};
   assign w_hold_mask = 4'b0001 << r_last;
   // Any requester other than the current holder is waiting.
   assign w_others    = |(w_req & ~w_hold_mask);

   // Circular search starting just after the last grant, so the last holder
   // ends up with the lowest priority.
   always_comb begin
      logic [1:0] v_idx;
      w_win_vld = 1'b0;
      w_win_idx = 2'd0;
      v_idx     = 2'd0;
      for (int i = 1; i <= 4; i++) begin
         v_idx = r_last + 2'(i);
         if (!w_win_vld && w_req[v_idx]) begin
            w_win_vld = 1'b1;
            w_win_idx = v_idx;
         end
      end
   end

   // Next-state and registered-output decode.
   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_last_nxt   = r_last;
      w_cnt_nxt    = r_cnt;
      w_expire_nxt = 1'b0;
      case (r_state)
         StIdle: begin
            w_gnt_nxt = 4'b0000;
            if (w_win_vld) begin
               w_state_nxt = StGrant;
               w_gnt_nxt   = 4'b0001 << w_win_idx;
               w_last_nxt  = w_win_idx;
               w_cnt_nxt   = 4'd1;
            end
         end
         StGrant: begin
            if (!w_req[r_last]) begin
               // Voluntary release never pulses expire, even at full quantum.
               w_state_nxt = StIdle;
               w_gnt_nxt   = 4'b0000;
            end else if (r_cnt < LP_QUANTUM) begin
               w_cnt_nxt = r_cnt + 4'd1;
            end else if (w_others) begin
               w_state_nxt  = StIdle;
               w_gnt_nxt    = 4'b0000;
               w_expire_nxt = 1'b1;
            end
            // Otherwise no contention: keep the grant, counter saturated.
         end
         default: begin
            w_state_nxt = StIdle;
            w_gnt_nxt   = 4'b0000;
         end
      endcase
      w_busy_nxt = |w_gnt_nxt;
   end

   // State and output registers; reset clears outputs without a clock edge.
   always_ff @(posedge i_clock or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= StIdle;
         r_gnt    <= 4'b0000;
         r_last   <= 2'd3;
         r_cnt    <= 4'd0;
         r_busy   <= 1'b0;
         r_expire <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_last   <= w_last_nxt;
         r_cnt    <= w_cnt_nxt;
         r_busy   <= w_busy_nxt;
         r_expire <= w_expire_nxt;
      end
   end

   assign o_gnt0   = r_gnt[0];
   assign o_gnt1   = r_gnt[1];
   assign o_gnt2   = r_gnt[2];
   assign o_gnt3   = r_gnt[3];
   assign o_gnt_id = r_last;
   assign o_busy   = r_busy;
   assign o_expire = r_expire;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter with QUANTUM=4 and hand-computed expectations.
module tb_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic       req0, req1, req2, req3;
   logic       gnt0, gnt1, gnt2, gnt3;
   logic [1:0] gnt_id;
   logic       busy;
   logic       expire;

   int n_vec = 0;
   int n_err = 0;

   rr_arbiter #(.QUANTUM(4)) dut (
      .i_clock  (clk),
      .i_rst_n  (rst_n),
      .i_req0   (req0),
      .i_req1   (req1),
      .i_req2   (req2),
      .i_req3   (req3),
      .o_gnt0   (gnt0),
      .o_gnt1   (gnt1),
      .o_gnt2   (gnt2),
      .o_gnt3   (gnt3),
      .o_gnt_id (gnt_id),
      .o_busy   (busy),
      .o_expire (expire)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 time unit after the next rising edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] eg, input logic [1:0] eid,
                      input logic eb, input logic ee);
      logic [3:0] g;
      g = {gnt3, gnt2, gnt1, gnt0};
      n_vec++;
      assert (g === eg) else begin
         n_err++;
         $error("FAIL %s gnt: got %b want %b", tag, g, eg);
      end
      n_vec++;
      assert (gnt_id === eid) else begin
         n_err++;
         $error("FAIL %s gnt_id: got %0d want %0d", tag, gnt_id, eid);
      end
      n_vec++;
      assert (busy === eb) else begin
         n_err++;
         $error("FAIL %s busy: got %b want %b", tag, busy, eb);
      end
      n_vec++;
      assert (expire === ee) else begin
         n_err++;
         $error("FAIL %s expire: got %b want %b", tag, expire, ee);
      end
   endtask

   // Called at posedge+1: reset low, check, release at the falling edge.
   task automatic do_reset();
      rst_n = 1'b0;
      #2;
      chk("reset", 4'b0000, 2'd3, 1'b0, 1'b0);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [1:0] k;
      rst_n = 1'b0;
      req0 = 1'b0; req1 = 1'b0; req2 = 1'b0; req3 = 1'b0;

      // Scenario 1: req0 alone for 3 cycles.
      step();
      do_reset();
      req0 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("s1_gnt0", 4'b0001, 2'd0, 1'b1, 1'b0);
      end
      req0 = 1'b0;
      step();
      chk("s1_release", 4'b0000, 2'd0, 1'b0, 1'b0);

      // Scenario 2: all requesters held high from reset release.
      req0 = 1'b1; req1 = 1'b1; req2 = 1'b1; req3 = 1'b1;
      do_reset();
      for (int r = 0; r < 5; r++) begin
         k = 2'(r);
         for (int c = 0; c < 4; c++) begin
            step();
            chk("s2_hold", 4'b0001 << k, k, 1'b1, 1'b0);
         end
         if (r < 4) begin
            step();
            chk("s2_turn", 4'b0000, k, 1'b0, 1'b1);
         end
      end

      // Scenario 3: release gnt0, then req3 alone for 20 cycles.
      req0 = 1'b0; req1 = 1'b0; req2 = 1'b0; req3 = 1'b0;
      step();
      chk("s3_release0", 4'b0000, 2'd0, 1'b0, 1'b0);
      req3 = 1'b1;
      for (int c = 0; c < 20; c++) begin
         step();
         chk("s3_gnt3", 4'b1000, 2'd3, 1'b1, 1'b0);
      end
      req3 = 1'b0;
      step();
      chk("s3_release3", 4'b0000, 2'd3, 1'b0, 1'b0);

      // Scenario 4: req2 rises in the 2nd gnt1 cycle; gnt1 revoked.
      req1 = 1'b1;
      step();
      chk("s4_gnt1_c1", 4'b0010, 2'd1, 1'b1, 1'b0);
      step();
      chk("s4_gnt1_c2", 4'b0010, 2'd1, 1'b1, 1'b0);
      req2 = 1'b1;
      step();
      chk("s4_gnt1_c3", 4'b0010, 2'd1, 1'b1, 1'b0);
      step();
      chk("s4_gnt1_c4", 4'b0010, 2'd1, 1'b1, 1'b0);
      step();
      chk("s4_expire", 4'b0000, 2'd1, 1'b0, 1'b1);
      step();
      chk("s4_gnt2_c1", 4'b0100, 2'd2, 1'b1, 1'b0);
      req1 = 1'b0;
      step();
      chk("s4_gnt2_c2", 4'b0100, 2'd2, 1'b1, 1'b0);
      req2 = 1'b0;
      step();
      chk("s4_release2", 4'b0000, 2'd2, 1'b0, 1'b0);

      // Scenario 5: req1 drops in its 4th cycle with req2 waiting.
      req1 = 1'b1; req2 = 1'b1;
      for (int c = 0; c < 4; c++) begin
         step();
         chk("s5_gnt1", 4'b0010, 2'd1, 1'b1, 1'b0);
      end
      req1 = 1'b0;
      step();
      chk("s5_noexpire", 4'b0000, 2'd1, 1'b0, 1'b0);
      step();
      chk("s5_gnt2", 4'b0100, 2'd2, 1'b1, 1'b0);

      // Scenario 6: asynchronous reset mid-gnt2, release with req0 and req2.
      #3;
      rst_n = 1'b0;
      #1;
      chk("s6_async_rst", 4'b0000, 2'd3, 1'b0, 1'b0);
      req0 = 1'b1;
      #2;
      rst_n = 1'b1;
      step();
      chk("s6_first_gnt0", 4'b0001, 2'd0, 1'b1, 1'b0);
      req0 = 1'b0; req2 = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
